// File: rtl/voice_allocator_if.sv
// Note-event handshake between a note source and the voice allocator.
interface voice_allocator_if #(
    parameter int unsigned NOTE_W = 7
);
    logic              NoteValid;
    logic              NoteReady;
    logic              NoteOn;
    logic [NOTE_W-1:0] NoteNum;

    modport master (output NoteValid, output NoteOn, output NoteNum, input NoteReady);
    modport slave  (input NoteValid, input NoteOn, input NoteNum, output NoteReady);
endinterface

// File: rtl/voice_allocator.sv
// Four-voice note allocator driving ADSR gates with retrigger, idle, released and LRU stealing.
// Define VOICE_ALLOCATOR_STEAL_EN to steal the oldest held voice instead of dropping the note-on.
module voice_allocator #(
    parameter int unsigned NOTE_W     = 7,
    parameter int unsigned NUM_VOICES = 4
) (
    input  logic                         Clock,
    input  logic                         Reset,
    voice_allocator_if.slave             evt,
    input  logic [NUM_VOICES-1:0]        VoiceRunning,
    output logic [NUM_VOICES-1:0]        VoiceGate,
    output logic [NUM_VOICES*NOTE_W-1:0] VoiceNote,
    output logic [1:0]                   AllocVoice,
    output logic                         AllocValid,
    output logic                         DropPulse
);

    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {IDLE, LOOKUP, ARM, FIRE} state_t;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic                on_q, on_d;
    logic [NOTE_W-1:0]   num_q, num_d;
    logic [IDX_W-1:0]    tgt_q, tgt_d;
    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [NOTE_W-1:0]   note_q [NUM_VOICES];
    logic [NOTE_W-1:0]   note_d [NUM_VOICES];
    logic [IDX_W-1:0]    rank_q [NUM_VOICES];
    logic [IDX_W-1:0]    rank_d [NUM_VOICES];
    logic [IDX_W-1:0]    alloc_voice_q, alloc_voice_d;
    logic                alloc_valid_q, alloc_valid_d;
    logic                drop_q, drop_d;

    logic                accept_c;
    logic                retrig_hit, idle_hit, rel_hit;
    logic [IDX_W-1:0]    retrig_idx, idle_idx, rel_idx, rel_rank;
`ifdef VOICE_ALLOCATOR_STEAL_EN
    logic                held_hit;
    logic [IDX_W-1:0]    held_idx, held_rank;
`endif
    logic                tgt_found;
    logic [IDX_W-1:0]    tgt_sel;

    assign accept_c = evt.NoteValid && ready_q;

    // Target search over the latched note; only meaningful while in LOOKUP.
    always_comb begin
        retrig_hit = 1'b0;
        retrig_idx = '0;
        idle_hit   = 1'b0;
        idle_idx   = '0;
        rel_hit    = 1'b0;
        rel_idx    = '0;
        rel_rank   = '0;
`ifdef VOICE_ALLOCATOR_STEAL_EN
        held_hit   = 1'b0;
        held_idx   = '0;
        held_rank  = '0;
`endif
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (gate_q[i] && (note_q[i] == num_q) && !retrig_hit) begin
                retrig_hit = 1'b1;
                retrig_idx = IDX_W'(i);
            end
            if (!gate_q[i] && !VoiceRunning[i] && !idle_hit) begin
                idle_hit = 1'b1;
                idle_idx = IDX_W'(i);
            end
            if (!gate_q[i] && VoiceRunning[i] && (!rel_hit || (rank_q[i] > rel_rank))) begin
                rel_hit  = 1'b1;
                rel_idx  = IDX_W'(i);
                rel_rank = rank_q[i];
            end
`ifdef VOICE_ALLOCATOR_STEAL_EN
            if (gate_q[i] && (!held_hit || (rank_q[i] > held_rank))) begin
                held_hit  = 1'b1;
                held_idx  = IDX_W'(i);
                held_rank = rank_q[i];
            end
`endif
        end

        tgt_found = 1'b1;
        tgt_sel   = '0;
        if (retrig_hit) begin
            tgt_sel = retrig_idx;
        end else if (idle_hit) begin
            tgt_sel = idle_idx;
        end else if (rel_hit) begin
            tgt_sel = rel_idx;
`ifdef VOICE_ALLOCATOR_STEAL_EN
        end else if (held_hit) begin
            tgt_sel = held_idx;
`endif
        end else begin
            tgt_found = 1'b0;
        end
    end

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = LOOKUP;
            LOOKUP:  state_d = (on_q && tgt_found) ? ARM : IDLE;
            ARM:     state_d = FIRE;
            FIRE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        ready_d       = (state_d == IDLE);
        on_d          = on_q;
        num_d         = num_q;
        tgt_d         = tgt_q;
        gate_d        = gate_q;
        note_d        = note_q;
        rank_d        = rank_q;
        alloc_voice_d = alloc_voice_q;
        alloc_valid_d = 1'b0;
        drop_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    on_d  = evt.NoteOn;
                    num_d = evt.NoteNum;
                end
            end
            LOOKUP: begin
                if (!on_q) begin
                    for (int i = 0; i < int'(NUM_VOICES); i++) begin
                        if (gate_q[i] && (note_q[i] == num_q)) gate_d[i] = 1'b0;
                    end
                end else if (tgt_found) begin
                    // Gate dropped here so the rise at the end of ARM is always a fresh edge.
                    note_d[tgt_sel] = num_q;
                    gate_d[tgt_sel] = 1'b0;
                    alloc_voice_d   = tgt_sel;
                    tgt_d           = tgt_sel;
                end else begin
                    drop_d = 1'b1;
                end
            end
            ARM: begin
                gate_d[tgt_q] = 1'b1;
                alloc_valid_d = 1'b1;
                for (int i = 0; i < int'(NUM_VOICES); i++) begin
                    if (IDX_W'(i) == tgt_q) begin
                        rank_d[i] = '0;
                    end else if (rank_q[i] < rank_q[tgt_q]) begin
                        rank_d[i] = rank_q[i] + IDX_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ready_q       <= 1'b1;
            on_q          <= 1'b0;
            num_q         <= '0;
            tgt_q         <= '0;
            gate_q        <= '0;
            alloc_voice_q <= '0;
            alloc_valid_q <= 1'b0;
            drop_q        <= 1'b0;
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                note_q[i] <= '0;
                rank_q[i] <= IDX_W'(i);
            end
        end else begin
            ready_q       <= ready_d;
            on_q          <= on_d;
            num_q         <= num_d;
            tgt_q         <= tgt_d;
            gate_q        <= gate_d;
            alloc_voice_q <= alloc_voice_d;
            alloc_valid_q <= alloc_valid_d;
            drop_q        <= drop_d;
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                note_q[i] <= note_d[i];
                rank_q[i] <= rank_d[i];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < int'(NUM_VOICES); g++) begin : g_note
            assign VoiceNote[g*NOTE_W +: NOTE_W] = note_q[g];
        end
    endgenerate

    assign evt.NoteReady = ready_q;
    assign VoiceGate     = gate_q;
    assign AllocVoice    = alloc_voice_q;
    assign AllocValid    = alloc_valid_q;
    assign DropPulse     = drop_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator; expectations follow the build's steal option.
module tb_voice_allocator;

    localparam int unsigned NOTE_W = 7;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic [3:0]    VoiceRunning = 4'b0000;
    logic [3:0]    VoiceGate;
    logic [27:0]   VoiceNote;
    logic [1:0]    AllocVoice;
    logic          AllocValid;
    logic          DropPulse;

    int checks = 0;
    int errors = 0;

    voice_allocator_if #(.NOTE_W(NOTE_W)) nif ();

    voice_allocator #(.NOTE_W(NOTE_W), .NUM_VOICES(4)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .evt          (nif),
        .VoiceRunning (VoiceRunning),
        .VoiceGate    (VoiceGate),
        .VoiceNote    (VoiceNote),
        .AllocVoice   (AllocVoice),
        .AllocValid   (AllocValid),
        .DropPulse    (DropPulse)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] vn(input int i);
        return 32'(VoiceNote[i*NOTE_W +: NOTE_W]);
    endfunction

    task automatic tick();
        @(negedge Clock);
    endtask

    // Offer one event, then scramble the inputs while the allocator is busy.
    task automatic send(input logic on, input logic [NOTE_W-1:0] num);
        int n = 0;
        while (!nif.NoteReady && n < 20) begin
            tick();
            n++;
        end
        if (!nif.NoteReady) chk("ready_timeout", 32'(nif.NoteReady), 32'd1);
        nif.NoteValid = 1'b1;
        nif.NoteOn    = on;
        nif.NoteNum   = num;
        tick();
        nif.NoteValid = 1'b0;
        nif.NoteOn    = ~on;
        nif.NoteNum   = 7'h7f;
    endtask

    task automatic note_on_full(input logic [NOTE_W-1:0] num);
        send(1'b1, num);
        tick();
        tick();
        tick();
    endtask

    task automatic note_off_full(input logic [NOTE_W-1:0] num);
        send(1'b0, num);
        tick();
    endtask

    task automatic do_reset();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        VoiceRunning = 4'b0000;
    endtask

    initial begin
        nif.NoteValid = 1'b0;
        nif.NoteOn    = 1'b0;
        nif.NoteNum   = '0;

        // Reset values
        tick();
        tick();
        chk("rst_gate",   32'(VoiceGate),  32'h0);
        chk("rst_note",   32'(VoiceNote),  32'h0);
        chk("rst_alloc",  32'(AllocVoice), 32'h0);
        chk("rst_valid",  32'(AllocValid), 32'h0);
        chk("rst_drop",   32'(DropPulse),  32'h0);
        Reset = 1'b0;
        #1;
        chk("rst_ready",  32'(nif.NoteReady), 32'h1);

        // First note-on lands on voice 0; gate low in ARM, high after ARM ends
        send(1'b1, 7'd60);
        chk("lookup_ready", 32'(nif.NoteReady), 32'h0);
        tick();
        chk("arm_gate",   32'(VoiceGate),  32'h0);
        chk("arm_note0",  vn(0),           32'd60);
        chk("arm_alloc",  32'(AllocVoice), 32'h0);
        chk("arm_valid",  32'(AllocValid), 32'h0);
        tick();
        chk("fire_gate",  32'(VoiceGate),  32'h1);
        chk("fire_valid", 32'(AllocValid), 32'h1);
        tick();
        chk("idle_valid", 32'(AllocValid), 32'h0);
        chk("idle_ready", 32'(nif.NoteReady), 32'h1);

        // Fill remaining voices
        note_on_full(7'd62);
        note_on_full(7'd64);
        note_on_full(7'd67);
        chk("fill_gate",  32'(VoiceGate),  32'hf);
        chk("fill_note1", vn(1),           32'd62);
        chk("fill_note2", vn(2),           32'd64);
        chk("fill_note3", vn(3),           32'd67);
        chk("fill_alloc", 32'(AllocVoice), 32'h3);

        // Note-off matching and non-matching
        note_off_full(7'd62);
        chk("off62_gate", 32'(VoiceGate),  32'hd);
        note_off_full(7'd50);
        chk("off50_gate", 32'(VoiceGate),  32'hd);
        chk("off50_note1", vn(1),          32'd62);

        // Retrigger voice 0 beats idle voice 1
        send(1'b1, 7'd60);
        tick();
        chk("retrig_low",   32'(VoiceGate),  32'hc);
        chk("retrig_alloc", 32'(AllocVoice), 32'h0);
        tick();
        chk("retrig_high",  32'(VoiceGate),  32'hd);
        chk("retrig_valid", 32'(AllocValid), 32'h1);
        tick();
        chk("retrig_note0", vn(0),           32'd60);

        // Idle voice 3 preferred over released voice 1
        note_off_full(7'd67);
        chk("off67_gate", 32'(VoiceGate), 32'h5);
        VoiceRunning = 4'b0010;
        send(1'b1, 7'd70);
        tick();
        chk("idle_alloc", 32'(AllocVoice), 32'h3);
        tick();
        tick();
        chk("idle_gate",  32'(VoiceGate),  32'hd);
        chk("idle_note3", vn(3),           32'd70);

        // No idle: oldest released (voice 1, rank 3) beats voice 0 (rank 1)
        note_off_full(7'd60);
        chk("off60_gate", 32'(VoiceGate), 32'hc);
        VoiceRunning = 4'b0011;
        note_on_full(7'd71);
        chk("rel_alloc", 32'(AllocVoice), 32'h1);
        chk("rel_note1", vn(1),           32'd71);
        chk("rel_gate",  32'(VoiceGate),  32'he);

        // All four held, then another note-on
        do_reset();
        note_on_full(7'd60);
        note_on_full(7'd62);
        note_on_full(7'd64);
        note_on_full(7'd67);
        VoiceRunning = 4'b1111;
        send(1'b1, 7'd72);
        tick();
`ifdef VOICE_ALLOCATOR_STEAL_EN
        chk("steal_low",   32'(VoiceGate),  32'he);
        chk("steal_alloc", 32'(AllocVoice), 32'h0);
        chk("steal_note0", vn(0),           32'd72);
        chk("steal_drop",  32'(DropPulse),  32'h0);
        tick();
        chk("steal_high",  32'(VoiceGate),  32'hf);
        chk("steal_valid", 32'(AllocValid), 32'h1);
        tick();
`else
        chk("drop_pulse", 32'(DropPulse),  32'h1);
        chk("drop_gate",  32'(VoiceGate),  32'hf);
        chk("drop_alloc", 32'(AllocVoice), 32'h3);
        chk("drop_note0", vn(0),           32'd60);
        chk("drop_ready", 32'(nif.NoteReady), 32'h1);
        tick();
        chk("drop_clear", 32'(DropPulse),  32'h0);
        chk("drop_valid", 32'(AllocValid), 32'h0);
        chk("drop_gate2", 32'(VoiceGate),  32'hf);
`endif

        // Reset during ARM abandons the event
        do_reset();
        send(1'b1, 7'd55);
        tick();
        Reset = 1'b1;
        #1;
        chk("armrst_gate",  32'(VoiceGate),  32'h0);
        chk("armrst_note0", vn(0),           32'd0);
        tick();
        chk("armrst_valid", 32'(AllocValid), 32'h0);
        Reset = 1'b0;
        #1;
        chk("armrst_ready", 32'(nif.NoteReady), 32'h1);
        tick();
        tick();
        chk("armrst_gate2",  32'(VoiceGate),  32'h0);
        chk("armrst_valid2", 32'(AllocValid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
